pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter FRAME_DIV, default 307200: CLOCK_50 cycles per game frame.
REQ-002 Parameter SERVE_HOLDOFF, default 500: frames that must elapse in SERVE before a serve is accepted.
REQ-003 Parameter WIN_SCORE, default 9: points that end the game (range 1..15).
REQ-004 CLOCK_50  input  1  system clock.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 serve_p1  input  1  player 1 serve request, active-high level.
REQ-007 serve_p2  input  1  player 2 serve request, active-high level.
REQ-008 miss_left  input  1  ball passed the left goal line, sampled only on frame_en.
REQ-009 miss_right  input  1  ball passed the right goal line, sampled only on frame_en.
REQ-010 frame_en  output  1  one-cycle pulse once per frame; the datapath updates positions only on it.
REQ-011 ball_hold  output  1  high while the ball is held at centre (all states except PLAY).
REQ-012 ball_launch  output  1  one-cycle pulse that starts ball motion.
REQ-013 launch_dir  output  1  0 = toward the right (player 1 served), 1 = toward the left; valid with ball_launch and held afterwards.
REQ-014 score_p1 / score_p2  output  4 each  current scores.
REQ-015 game_over  output  1  high in GAME_OVER.
REQ-016 winner  output  1  0 = player 1, 1 = player 2; valid while game_over.
REQ-017 state  output  3  current FSM state encoding, for debug.

Function
REQ-018 The frame counter SHALL count 0..FRAME_DIV-1 and wrap; frame_en SHALL pulse in the cycle the counter equals FRAME_DIV-1.
REQ-019 The FSM states SHALL be SERVE, PLAY, POINT and GAME_OVER, and all transitions SHALL occur only in frame_en cycles.
REQ-020 SERVE: the holdoff counter increments per frame, saturating at SERVE_HOLDOFF.
REQ-021 SERVE exit:
- Condition: holdoff saturated and a serve input high at frame_en.
- Action: go to PLAY, pulse ball_launch in that same cycle, clear the holdoff counter.
REQ-022 When serve_p1 and serve_p2 are both high in the accepting cycle, player 1 SHALL win the serve (launch_dir=0).
REQ-023 PLAY, miss_left at frame_en: increment score_p2 and go to POINT.
REQ-024 PLAY, miss_right at frame_en: increment score_p1 and go to POINT.
REQ-025 PLAY, miss_left and miss_right together: only miss_left is honoured.
REQ-026 PLAY, no miss: remain in PLAY.
REQ-027 POINT SHALL last exactly one frame, then go to:
- GAME_OVER if either score equals WIN_SCORE (winner set accordingly);
- otherwise SERVE.
REQ-028 Scores SHALL never exceed WIN_SCORE; increments are 4-bit with no wrap.
REQ-029 GAME_OVER: serve_p1 and serve_p2 both high at frame_en clears both scores and the holdoff counter and goes to SERVE; a single button has no effect.
REQ-030 miss inputs outside PLAY, or outside frame_en cycles, SHALL be ignored.
REQ-031 All outputs SHALL be registered; ball_launch latency is 0 cycles from the accepting frame_en edge and is visible on the next clock edge.

Reset
REQ-032 Reset SHALL force:
- state=SERVE, frame counter=0, holdoff=0, scores=0;
- ball_hold=1, ball_launch=0, launch_dir=0, frame_en=0, game_over=0, winner=0.
REQ-033 Reset asserted mid-PLAY or mid-GAME_OVER SHALL take effect at the next clock edge with no residual pulse.

Configuration
REQ-034 With PONG_PAUSE_EN defined:
- an input pause_btn (1 bit, active-high) is added;
- each rising edge of pause_btn toggles an internal paused flag;
- while paused, frame_en is suppressed and the frame counter freezes;
- reset clears paused.
REQ-035 Without PONG_PAUSE_EN, pause_btn is absent and frame_en is never suppressed.

Structure
REQ-036 Package pong_pkg SHALL hold:
- the state enum (SERVE, PLAY, POINT, GAME_OVER);
- the score type (4-bit);
- the direction constants DIR_RIGHT=0 and DIR_LEFT=1.
REQ-037 Frame-rate counter and frame_en generation SHALL be a sub-module, frame_tick_gen, parameterised by FRAME_DIV.

Verification
REQ-038 All scenarios below use FRAME_DIV=4, SERVE_HOLDOFF=2, WIN_SCORE=3.
REQ-039 Reset, then idle 20 cycles -> frame_en every 4th cycle, state=SERVE, ball_hold=1, scores 0/0.
REQ-040 serve_p2 held from cycle 0 -> no launch before the 3rd frame_en; launch on the 3rd frame_en with launch_dir=1; ball_hold falls.
REQ-041 In PLAY, miss_right at frame_en -> score_p1=1, POINT for one frame, then SERVE; holdoff restarts from 0.
REQ-042 In PLAY, miss_left and miss_right together -> score_p2 increments, score_p1 unchanged.
REQ-043 Player 1 scores 3 points -> game_over=1, winner=0; serve_p1 alone ignored; both serves -> scores 0/0, SERVE.
REQ-044 With PONG_PAUSE_EN: pause pulse during PLAY -> no frame_en for 40 cycles; a second pulse resumes frame_en with counter phase preserved.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller.
package pong_pkg;

    typedef enum logic [2:0] {
        SERVE     = 3'd0,
        PLAY      = 3'd1,
        POINT     = 3'd2,
        GAME_OVER = 3'd3
    } state_t;

    typedef logic [3:0] score_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Score increment that holds at the limit instead of wrapping.
    function automatic score_t score_inc(input score_t s, input score_t lim);
        return (s < lim) ? s + 4'd1 : s;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player/datapath-facing signals of the pong game controller.
interface pong_game_ctrl_if;
    import pong_pkg::*;

    logic       serve_p1;
    logic       serve_p2;
    logic       miss_left;
    logic       miss_right;
    logic       frame_en;
    logic       ball_hold;
    logic       ball_launch;
    logic       launch_dir;
    score_t     score_p1;
    score_t     score_p2;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    modport master (
        input  serve_p1, serve_p2, miss_left, miss_right,
        output frame_en, ball_hold, ball_launch, launch_dir,
        output score_p1, score_p2, game_over, winner, state
    );

    modport slave (
        output serve_p1, serve_p2, miss_left, miss_right,
        input  frame_en, ball_hold, ball_launch, launch_dir,
        input  score_p1, score_p2, game_over, winner, state
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Frame-rate divider: counts 0..FRAME_DIV-1 while run is high and emits a
// registered frame_en pulse in the cycle the counter sits at FRAME_DIV-1.
module frame_tick_gen #(
    parameter int FRAME_DIV = 307200
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    output logic frame_en
);

    localparam int              CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end

    // frame_en is computed from the next count so it lines up with cnt == LAST.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt      <= '0;
            frame_en <= 1'b0;
        end else if (run) begin
            cnt      <= cnt_next;
            frame_en <= (cnt_next == LAST);
        end else begin
            frame_en <= 1'b0;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: serve / play / point / game-over sequencing.
// Optional pause button enabled by defining PONG_PAUSE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int FRAME_DIV     = 307200,
    parameter int SERVE_HOLDOFF = 500,
    parameter int WIN_SCORE     = 9
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
`ifdef PONG_PAUSE_EN
    input  logic                    pause_btn,
`endif
    pong_game_ctrl_if.master        bus
);

    localparam int               HOLD_W   = (SERVE_HOLDOFF > 0) ? $clog2(SERVE_HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(SERVE_HOLDOFF);
    localparam score_t           WIN_L    = score_t'(WIN_SCORE);

    logic              tick_run;
    logic              frame_en;
    state_t            st;
    logic [HOLD_W-1:0] holdoff;
    score_t            score_p1;
    score_t            score_p2;
    logic              ball_hold;
    logic              ball_launch;
    logic              launch_dir;
    logic              game_over;
    logic              winner;

`ifdef PONG_PAUSE_EN
    logic pause_q;
    logic paused;

    // Each press of the pause button flips the paused flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pause_q <= 1'b0;
            paused  <= 1'b0;
        end else begin
            pause_q <= pause_btn;
            if (pause_btn && !pause_q)
                paused <= ~paused;
        end
    end

    assign tick_run = ~paused;
`else
    assign tick_run = 1'b1;
`endif

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .run      (tick_run),
        .frame_en (frame_en)
    );

    // All game decisions are taken only on frame boundaries.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            st          <= SERVE;
            holdoff     <= '0;
            score_p1    <= '0;
            score_p2    <= '0;
            ball_hold   <= 1'b1;
            ball_launch <= 1'b0;
            launch_dir  <= DIR_RIGHT;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            ball_launch <= 1'b0;
            if (frame_en) begin
                case (st)
                    SERVE: begin
                        if (holdoff == HOLD_MAX && (bus.serve_p1 || bus.serve_p2)) begin
                            st          <= PLAY;
                            ball_hold   <= 1'b0;
                            ball_launch <= 1'b1;
                            launch_dir  <= bus.serve_p1 ? DIR_RIGHT : DIR_LEFT;
                            holdoff     <= '0;
                        end else if (holdoff != HOLD_MAX) begin
                            holdoff <= holdoff + HOLD_W'(1);
                        end
                    end
                    PLAY: begin
                        // A simultaneous double miss is credited to player 2.
                        if (bus.miss_left) begin
                            score_p2  <= score_inc(score_p2, WIN_L);
                            st        <= POINT;
                            ball_hold <= 1'b1;
                        end else if (bus.miss_right) begin
                            score_p1  <= score_inc(score_p1, WIN_L);
                            st        <= POINT;
                            ball_hold <= 1'b1;
                        end
                    end
                    POINT: begin
                        if (score_p1 == WIN_L || score_p2 == WIN_L) begin
                            st        <= GAME_OVER;
                            game_over <= 1'b1;
                            winner    <= (score_p1 != WIN_L);
                        end else begin
                            st      <= SERVE;
                            holdoff <= '0;
                        end
                    end
                    GAME_OVER: begin
                        if (bus.serve_p1 && bus.serve_p2) begin
                            st        <= SERVE;
                            game_over <= 1'b0;
                            score_p1  <= '0;
                            score_p2  <= '0;
                            holdoff   <= '0;
                        end
                    end
                    default: begin
                        st        <= SERVE;
                        ball_hold <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.frame_en    = frame_en;
    assign bus.ball_hold   = ball_hold;
    assign bus.ball_launch = ball_launch;
    assign bus.launch_dir  = launch_dir;
    assign bus.score_p1    = score_p1;
    assign bus.score_p2    = score_p2;
    assign bus.game_over   = game_over;
    assign bus.winner      = winner;
    assign bus.state       = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with FRAME_DIV=4, SERVE_HOLDOFF=2, WIN_SCORE=3.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
`ifdef PONG_PAUSE_EN
    logic pause_btn = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .FRAME_DIV     (4),
        .SERVE_HOLDOFF (2),
        .WIN_SCORE     (3)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
`ifdef PONG_PAUSE_EN
        .pause_btn (pause_btn),
`endif
        .bus       (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where frame_en is high (bounded).
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (!bus.frame_en && n < 8);
        if (!bus.frame_en)
            check({tag, " frame_en timeout"}, 32'(bus.frame_en), 32'd1);
    endtask

    task automatic serve_seq(input logic p1, input logic p2, input logic exp_dir, input string tag);
        bus.serve_p1 = p1;
        bus.serve_p2 = p2;
        for (int f = 1; f <= 2; f++) begin
            wait_frame(tag);
            @(negedge CLOCK_50);
            check({tag, " early state"}, 32'(bus.state), 32'(SERVE));
            check({tag, " early launch"}, 32'(bus.ball_launch), 32'd0);
        end
        wait_frame(tag);
        @(negedge CLOCK_50);
        check({tag, " state"}, 32'(bus.state), 32'(PLAY));
        check({tag, " launch"}, 32'(bus.ball_launch), 32'd1);
        check({tag, " dir"}, 32'(bus.launch_dir), 32'(exp_dir));
        check({tag, " hold"}, 32'(bus.ball_hold), 32'd0);
        bus.serve_p1 = 1'b0;
        bus.serve_p2 = 1'b0;
        @(negedge CLOCK_50);
        check({tag, " launch pulse"}, 32'(bus.ball_launch), 32'd0);
        check({tag, " dir held"}, 32'(bus.launch_dir), 32'(exp_dir));
    endtask

    // Score one point from PLAY, then pass through POINT.
    task automatic play_point(input logic ml, input logic mr, input int s1, input int s2, input string tag);
        bus.miss_left  = ml;
        bus.miss_right = mr;
        wait_frame(tag);
        @(negedge CLOCK_50);
        check({tag, " point state"}, 32'(bus.state), 32'(POINT));
        check({tag, " p1"}, 32'(bus.score_p1), 32'(s1));
        check({tag, " p2"}, 32'(bus.score_p2), 32'(s2));
        check({tag, " hold"}, 32'(bus.ball_hold), 32'd1);
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        wait_frame(tag);
        @(negedge CLOCK_50);
    endtask

    initial begin
        int pulses;
        int bad;
        bus.serve_p1   = 1'b0;
        bus.serve_p2   = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check("rst state", 32'(bus.state), 32'(SERVE));
        check("rst hold", 32'(bus.ball_hold), 32'd1);
        check("rst launch", 32'(bus.ball_launch), 32'd0);
        check("rst dir", 32'(bus.launch_dir), 32'd0);
        check("rst frame_en", 32'(bus.frame_en), 32'd0);
        check("rst game_over", 32'(bus.game_over), 32'd0);
        check("rst winner", 32'(bus.winner), 32'd0);
        check("rst scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);

        // Idle 20 cycles: frame_en at cycles 3,7,11,15,19
        reset  = 1'b0;
        pulses = 0;
        bad    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (bus.frame_en) begin
                pulses++;
                if ((i % 4) != 3) bad++;
            end
        end
        check("idle pulses", 32'(pulses), 32'd5);
        check("idle phase", 32'(bad), 32'd0);
        check("idle state", 32'(bus.state), 32'(SERVE));
        check("idle hold", 32'(bus.ball_hold), 32'd1);
        check("idle scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);

        // serve_p2 held from reset release: launch on 3rd frame toward the left
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        serve_seq(1'b0, 1'b1, DIR_LEFT, "serve_p2");

        // miss_right: player 1 scores; misses ignored outside PLAY
        bus.miss_right = 1'b1;
        wait_frame("miss_r");
        @(negedge CLOCK_50);
        check("miss_r state", 32'(bus.state), 32'(POINT));
        check("miss_r p1", 32'(bus.score_p1), 32'd1);
        check("miss_r p2", 32'(bus.score_p2), 32'd0);
        bus.miss_right = 1'b0;
        bus.miss_left  = 1'b1;
        wait_frame("point");
        @(negedge CLOCK_50);
        check("point->serve", 32'(bus.state), 32'(SERVE));
        check("point ignores miss", 32'(bus.score_p2), 32'd0);
        bus.miss_left = 1'b0;
        serve_seq(1'b1, 1'b0, DIR_RIGHT, "serve_p1");

        // Double miss: only miss_left counts
        play_point(1'b1, 1'b1, 1, 1, "double");
        check("double serve", 32'(bus.state), 32'(SERVE));

        // Both serve buttons: player 1 wins the serve
        serve_seq(1'b1, 1'b1, DIR_RIGHT, "serve_both");
        play_point(1'b0, 1'b1, 2, 1, "p1_2");
        check("p1_2 serve", 32'(bus.state), 32'(SERVE));
        serve_seq(1'b1, 1'b0, DIR_RIGHT, "serve_p1b");
        play_point(1'b0, 1'b1, 3, 1, "p1_3");
        check("go state", 32'(bus.state), 32'(GAME_OVER));
        check("go flag", 32'(bus.game_over), 32'd1);
        check("go winner", 32'(bus.winner), 32'd0);
        check("go hold", 32'(bus.ball_hold), 32'd1);

        // Single serve ignored in GAME_OVER; both restart
        bus.serve_p1 = 1'b1;
        wait_frame("go_single");
        @(negedge CLOCK_50);
        check("go single state", 32'(bus.state), 32'(GAME_OVER));
        check("go single scores", 32'({bus.score_p1, bus.score_p2}), 32'h31);
        bus.serve_p2 = 1'b1;
        wait_frame("go_both");
        @(negedge CLOCK_50);
        check("restart state", 32'(bus.state), 32'(SERVE));
        check("restart scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);
        check("restart flag", 32'(bus.game_over), 32'd0);
        bus.serve_p1 = 1'b0;
        bus.serve_p2 = 1'b0;

        // Player 2 wins a game
        for (int k = 1; k <= 3; k++) begin
            serve_seq(1'b0, 1'b1, DIR_LEFT, "serve_p2g");
            play_point(1'b1, 1'b0, 0, k, "p2pt");
        end
        check("p2 go state", 32'(bus.state), 32'(GAME_OVER));
        check("p2 winner", 32'(bus.winner), 32'd1);

        // Reset mid-GAME_OVER
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("rst go state", 32'(bus.state), 32'(SERVE));
        check("rst go flag", 32'(bus.game_over), 32'd0);
        check("rst go winner", 32'(bus.winner), 32'd0);
        check("rst go scores", 32'({bus.score_p1, bus.score_p2}), 32'd0);
        reset = 1'b0;

        serve_seq(1'b1, 1'b0, DIR_RIGHT, "serve_pre");

`ifdef PONG_PAUSE_EN
        // Pause during PLAY, then resume with phase preserved
        wait_frame("pause");
        pause_btn = 1'b1;
        @(negedge CLOCK_50);
        pause_btn = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (bus.frame_en) pulses++;
        end
        check("paused frame_en", 32'(pulses), 32'd0);
        check("paused state", 32'(bus.state), 32'(PLAY));
        pause_btn = 1'b1;
        pulses = 0;
        do begin
            @(negedge CLOCK_50);
            pause_btn = 1'b0;
            pulses++;
        end while (!bus.frame_en && pulses < 10);
        check("resume phase", 32'(pulses), 32'd4);
`endif

        // Reset mid-PLAY in a frame that would score: no residual effect
        bus.miss_right = 1'b1;
        wait_frame("rst_play");
        reset = 1'b1;
        @(negedge CLOCK_50);
        check("rst play state", 32'(bus.state), 32'(SERVE));
        check("rst play p1", 32'(bus.score_p1), 32'd0);
        check("rst play frame_en", 32'(bus.frame_en), 32'd0);
        check("rst play hold", 32'(bus.ball_hold), 32'd1);
        bus.miss_right = 1'b0;
        reset = 1'b0;
        @(negedge CLOCK_50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
